// File: rtl/lisa_qspi_arb.sv
// rtl/lisa_qspi_arb.sv - QSPI bus sequencer sharing one bus between flash fetch (CE0) and PSRAM data (CE1)
// Optional: LISA_QSPI_FIXED_PRIO_EN gives port A fixed priority instead of round-robin.
module lisa_qspi_arb #(
    parameter int ADDR_W      = 24,
    parameter int FLASH_DUMMY = 6,
    parameter int PSRAM_WAIT  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [15:0]       a_rdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_wdata,
    output logic [7:0]        b_rdata,
    output logic              b_ack,
    output logic              ce_latch,
    output logic              sclk,
    output logic [3:0]        dq_out,
    output logic [3:0]        dq_oe,
    input  logic [3:0]        dq_in
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_LATCH, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DESEL
    } state_t;

    localparam logic [7:0] CMD_LAST   = 8'd15;
    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_W / 2 - 1);
    localparam logic [7:0] FDUM_LAST  = 8'(2 * FLASH_DUMMY - 1);
    localparam logic [7:0] PWAIT_LAST = 8'(2 * PSRAM_WAIT - 1);

    state_t            state, state_nx;
    logic [7:0]        cnt, cnt_nx;
    logic              gnt_b, we_q;
    logic [ADDR_W-1:0] addr_sh;
    logic [7:0]        wdata_q;
    logic [15:0]       shift_q, shift_nx;
    logic              take, take_b, data_last;
    logic [7:0]        cmd_byte;
    logic [2:0]        cmd_bit;
`ifndef LISA_QSPI_FIXED_PRIO_EN
    logic              last_grant_b;
`endif

    always_comb begin
`ifdef LISA_QSPI_FIXED_PRIO_EN
        take_b = b_req && !a_req;
`else
        take_b = b_req && (!a_req || !last_grant_b);
`endif
        take     = a_req || b_req;
        cmd_byte = (gnt_b && we_q) ? 8'h38 : 8'hEB;
        cmd_bit  = 3'd7 - cnt[3:1];
        shift_nx = {shift_q[11:0], dq_in};
    end

    // cnt counts clk cycles inside a state; cnt[0] is the SCLK phase
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt + 8'd1;
        ce_latch  = 1'b0;
        sclk      = 1'b0;
        dq_out    = 4'h0;
        dq_oe     = 4'h0;
        a_ack     = 1'b0;
        b_ack     = 1'b0;
        data_last = 1'b0;
        case (state)
            S_INIT: begin
                // cnt 0 is the quiet cycle while rst is held
                if (cnt != 8'd0) begin
                    ce_latch = (cnt == 8'd1);
                    dq_oe    = 4'b0011;
                    dq_out   = 4'b0011;
                end
                if (cnt == 8'd2) begin
                    state_nx = S_IDLE;
                    cnt_nx   = 8'd0;
                end
            end
            S_IDLE: begin
                cnt_nx = 8'd0;
                if (take) state_nx = S_LATCH;
            end
            S_LATCH: begin
                ce_latch = (cnt == 8'd0);
                dq_oe    = 4'b0011;
                dq_out   = gnt_b ? 4'b0001 : 4'b0010;
                if (cnt == 8'd1) begin
                    state_nx = S_CMD;
                    cnt_nx   = 8'd0;
                end
            end
            S_CMD: begin
                sclk   = cnt[0];
                dq_oe  = 4'b0001;
                dq_out = {3'b000, cmd_byte[cmd_bit]};
                if (cnt == CMD_LAST) begin
                    state_nx = S_ADDR;
                    cnt_nx   = 8'd0;
                end
            end
            S_ADDR: begin
                sclk   = cnt[0];
                dq_oe  = 4'hF;
                dq_out = addr_sh[ADDR_W-1 -: 4];
                if (cnt == ADDR_LAST) begin
                    state_nx = (gnt_b && we_q) ? S_DATA : S_DUMMY;
                    cnt_nx   = 8'd0;
                end
            end
            S_DUMMY: begin
                sclk = cnt[0];
                // flash mode bits: two SCLKs of 0xF, then bus released
                if (!gnt_b && cnt < 8'd4) begin
                    dq_oe  = 4'hF;
                    dq_out = 4'hF;
                end
                if (cnt == (gnt_b ? PWAIT_LAST : FDUM_LAST)) begin
                    state_nx = S_DATA;
                    cnt_nx   = 8'd0;
                end
            end
            S_DATA: begin
                sclk = cnt[0];
                if (gnt_b && we_q) begin
                    dq_oe  = 4'hF;
                    dq_out = cnt[1] ? wdata_q[3:0] : wdata_q[7:4];
                end
                if (cnt == (gnt_b ? 8'd3 : 8'd7)) begin
                    data_last = 1'b1;
                    state_nx  = S_DESEL;
                    cnt_nx    = 8'd0;
                end
            end
            S_DESEL: begin
                ce_latch = (cnt == 8'd0);
                dq_oe    = 4'b0011;
                dq_out   = 4'b0011;
                if (cnt == 8'd1) begin
                    a_ack    = !gnt_b;
                    b_ack    = gnt_b;
                    state_nx = S_IDLE;
                    cnt_nx   = 8'd0;
                end
            end
            default: begin
                state_nx = S_INIT;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_INIT;
            cnt     <= 8'd0;
            gnt_b   <= 1'b0;
            we_q    <= 1'b0;
            addr_sh <= '0;
            wdata_q <= 8'h00;
            shift_q <= 16'h0000;
            a_rdata <= 16'h0000;
            b_rdata <= 8'h00;
`ifndef LISA_QSPI_FIXED_PRIO_EN
            last_grant_b <= 1'b1;
`endif
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == S_IDLE && take) begin
                gnt_b   <= take_b;
                we_q    <= take_b && b_we;
                addr_sh <= take_b ? b_addr : a_addr;
                wdata_q <= b_wdata;
`ifndef LISA_QSPI_FIXED_PRIO_EN
                last_grant_b <= take_b;
`endif
            end
            if (state == S_ADDR && cnt[0])
                addr_sh <= {addr_sh[ADDR_W-5:0], 4'h0};
            if (state == S_DATA && cnt[0])
                shift_q <= shift_nx;
            // first byte arrives in the high nibbles of the shift register
            if (data_last && !we_q) begin
                if (gnt_b) b_rdata <= shift_nx[7:0];
                else       a_rdata <= {shift_nx[7:0], shift_nx[15:8]};
            end
        end
    end

endmodule

// File: tb/tb_lisa_qspi_arb.sv
// tb/tb_lisa_qspi_arb.sv - bench for lisa_qspi_arb with flash/PSRAM device models and transaction-level reference
`timescale 1ns/1ps
module tb_lisa_qspi_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0;
    logic [23:0] a_addr = 24'h0;
    logic [15:0] a_rdata;
    logic        a_ack;
    logic        b_req = 1'b0;
    logic        b_we = 1'b0;
    logic [23:0] b_addr = 24'h0;
    logic [7:0]  b_wdata = 8'h0;
    logic [7:0]  b_rdata;
    logic        b_ack;
    logic        ce_latch, sclk;
    logic [3:0]  dq_out, dq_oe;
    logic [3:0]  dq_in = 4'h0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    lisa_qspi_arb dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_rdata(a_rdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ack(b_ack),
        .ce_latch(ce_latch), .sclk(sclk), .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [7:0] flash_set [int];
    logic [7:0] psram_dev [int];
    logic [7:0] psram_ref [int];

    function automatic logic [7:0] flash_byte(input int a);
        if (flash_set.exists(a)) return flash_set[a];
        return 8'(a * 7 + 3);
    endfunction

    function automatic logic [7:0] dev_rd(input int a);
        if (psram_dev.exists(a)) return psram_dev[a];
        return 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input int a);
        if (psram_ref.exists(a)) return psram_ref[a];
        return 8'h00;
    endfunction

    // Device side: external CE latches plus flash and PSRAM bus decoders
    logic        ce0_l = 1'b1, ce1_l = 1'b1, ce_latch_d = 1'b0, sclk_d = 1'b0;
    logic [1:0]  last_ce = 2'b00;
    int          latch_pulses = 0;
    int          edge_n = 0;
    int          k;
    logic [7:0]  dv_cmd = 8'h0, dv_wbyte = 8'h0, last_cmd = 8'h0, by;
    logic [23:0] dv_addr = 24'h0, last_addr = 24'h0;
    int          a_ack_cnt = 0, b_ack_cnt = 0;

    always @(negedge clk) begin
        if (a_ack) a_ack_cnt++;
        if (b_ack) b_ack_cnt++;
        if (ce_latch) begin
            chk("latch_oe", 32'(dq_oe), 32'h3);
            if (!ce_latch_d) latch_pulses++;
            if ((ce0_l && !dq_out[0]) || (ce1_l && !dq_out[1])) edge_n = 0;
            ce0_l   = dq_out[0];
            ce1_l   = dq_out[1];
            last_ce = dq_out[1:0];
            chk("ce_exclusive", 32'(ce0_l | ce1_l), 32'h1);
        end
        ce_latch_d = ce_latch;
        dq_in = 4'h0;
        if (sclk && !sclk_d && !(ce0_l && ce1_l)) begin
            k = edge_n;
            edge_n++;
            if (k < 8) begin
                chk("cmd_oe", 32'(dq_oe), 32'h1);
                dv_cmd = {dv_cmd[6:0], dq_out[0]};
            end else if (k < 14) begin
                chk("addr_oe", 32'(dq_oe), 32'hF);
                dv_addr = {dv_addr[19:0], dq_out};
                if (k == 13) begin
                    last_cmd  = dv_cmd;
                    last_addr = dv_addr;
                    if (!ce0_l) chk("flash_cmd", 32'(dv_cmd), 32'hEB);
                    else        chk("psram_cmd", 32'(dv_cmd == 8'hEB || dv_cmd == 8'h38), 32'h1);
                end
            end else if (!ce0_l) begin
                if (k < 16) begin
                    chk("mode_oe", 32'(dq_oe), 32'hF);
                    chk("mode_nib", 32'(dq_out), 32'hF);
                end else if (k < 20) begin
                    chk("fdummy_oe", 32'(dq_oe), 32'h0);
                end else if (k < 24) begin
                    chk("fdata_oe", 32'(dq_oe), 32'h0);
                    by = flash_byte(int'(dv_addr) + (k - 20) / 2);
                    dq_in = (k % 2 == 0) ? by[7:4] : by[3:0];
                end
            end else if (dv_cmd == 8'h38) begin
                if (k < 16) begin
                    chk("wdata_oe", 32'(dq_oe), 32'hF);
                    dv_wbyte = {dv_wbyte[3:0], dq_out};
                    if (k == 15) psram_dev[int'(dv_addr)] = dv_wbyte;
                end
            end else begin
                if (k < 20) begin
                    chk("pwait_oe", 32'(dq_oe), 32'h0);
                end else if (k < 22) begin
                    chk("pdata_oe", 32'(dq_oe), 32'h0);
                    by = dev_rd(int'(dv_addr));
                    dq_in = (k % 2 == 0) ? by[7:4] : by[3:0];
                end
            end
        end
        sclk_d = sclk;
    end

    // Transaction-level reference: bus busy windows, arbitration, ack cycles and data
    int          free_at = 0, a_due = 0, b_due = 0;
    bit          a_pend = 0, b_pend = 0, zero_chk = 0, started = 0, m_last_b = 1, gb, b_exp_rd = 0;
    logic [15:0] a_exp = 16'h0;
    logic [7:0]  b_exp = 8'h0;

    always @(negedge clk) begin
        if (started) begin
            if (zero_chk) begin
                chk("rst_zero_ctl", 32'({ce_latch, sclk, dq_out, dq_oe, a_ack, b_ack}), 32'h0);
                chk("rst_zero_rdata", 32'({a_rdata, b_rdata}), 32'h0);
            end
            chk("a_ack", 32'(a_ack), 32'(a_pend && a_due == cyc));
            if (a_pend && a_due == cyc) begin
                chk("a_rdata", 32'(a_rdata), 32'(a_exp));
                a_pend = 0;
            end
            chk("b_ack", 32'(b_ack), 32'(b_pend && b_due == cyc));
            if (b_pend && b_due == cyc) begin
                if (b_exp_rd) chk("b_rdata", 32'(b_rdata), 32'(b_exp));
                b_pend = 0;
            end
        end
        if (rst) begin
            started  = 1;
            a_pend   = 0;
            b_pend   = 0;
            free_at  = cyc + 4;
            m_last_b = 1;
            zero_chk = 1;
        end else begin
            zero_chk = 0;
            if (started && cyc >= free_at && (a_req || b_req)) begin
`ifdef LISA_QSPI_FIXED_PRIO_EN
                gb = b_req && !a_req;
`else
                gb = b_req && (!a_req || !m_last_b);
`endif
                if (gb) begin
                    b_pend   = 1;
                    b_exp_rd = !b_we;
                    if (b_we) begin
                        b_due = cyc + 36;
                        psram_ref[int'(b_addr)] = b_wdata;
                    end else begin
                        b_due = cyc + 48;
                        b_exp = ref_rd(int'(b_addr));
                    end
                    free_at = b_due + 1;
                end else begin
                    a_pend  = 1;
                    a_due   = cyc + 52;
                    a_exp   = {flash_byte(int'(a_addr) + 1), flash_byte(int'(a_addr))};
                    free_at = a_due + 1;
                end
                m_last_b = gb;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit want_b, output int at_cyc);
        at_cyc = -1;
        for (int n = 0; n < 200 && at_cyc < 0; n++) begin
            @(negedge clk);
            if (want_b ? b_ack : a_ack) at_cyc = cyc;
        end
        if (at_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack expected ack within 200 cycles");
        end
        tick(1);
    endtask

    task automatic acc_a(input logic [23:0] addr, output int lat);
        int n0, kk;
        a_addr = addr;
        a_req  = 1'b1;
        n0     = cyc;
        wait_ack(1'b0, kk);
        a_req  = 1'b0;
        lat    = kk - n0;
    endtask

    task automatic acc_b(input logic we, input logic [23:0] addr, input logic [7:0] wd, output int lat);
        int n0, kk;
        b_we    = we;
        b_addr  = addr;
        b_wdata = wd;
        b_req   = 1'b1;
        n0      = cyc;
        wait_ack(1'b1, kk);
        b_req   = 1'b0;
        lat     = kk - n0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        int lat, p0, cnt0;
        logic [2:0] order;
        int got;
        order = 3'b000;

        tick(3);
        rst = 1'b0;
        tick(10);
        chk("init_pulses", 32'(latch_pulses), 32'd1);
        chk("init_ce", 32'(last_ce), 32'h3);
        chk("idle_sclk", 32'(sclk), 32'h0);
        chk("idle_oe", 32'(dq_oe), 32'h0);

        flash_set[32'h100] = 8'h34;
        flash_set[32'h101] = 8'h12;
        acc_a(24'h000100, lat);
        chk("a_latency", 32'(lat), 32'd52);
        chk("a_data_lit", 32'(a_rdata), 32'h1234);
        chk("a_cmd_lit", 32'(last_cmd), 32'hEB);
        chk("a_addr_lit", 32'(last_addr), 32'h000100);

        acc_b(1'b1, 24'h000010, 8'hA5, lat);
        chk("bw_latency", 32'(lat), 32'd36);
        chk("bw_cmd_lit", 32'(last_cmd), 32'h38);
        chk("bw_mem_lit", 32'(dev_rd(32'h10)), 32'hA5);
        acc_b(1'b0, 24'h000010, 8'h00, lat);
        chk("br_latency", 32'(lat), 32'd48);
        chk("br_data_lit", 32'(b_rdata), 32'hA5);
        chk("br_cmd_lit", 32'(last_cmd), 32'hEB);

        a_addr = 24'h000200;
        b_we   = 1'b0;
        b_addr = 24'h000010;
        a_req  = 1'b1;
        b_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            got = 0;
            for (int n = 0; n < 200 && got == 0; n++) begin
                @(negedge clk);
                if (a_ack || b_ack) begin
                    got = 1;
                    order[i] = b_ack;
                end
            end
            if (got == 0) begin
                checks++;
                errors++;
                $display("FAIL rr_timeout: got no ack expected ack %0d", i);
            end
        end
        tick(1);
        a_req = 1'b0;
        b_req = 1'b0;
`ifdef LISA_QSPI_FIXED_PRIO_EN
        chk("grant_order", 32'(order), 32'b000);
`else
        chk("grant_order", 32'(order), 32'b010);
`endif

        tick(2);
        a_addr = 24'h000300;
        a_req  = 1'b1;
        tick(22);
        p0   = latch_pulses;
        cnt0 = a_ack_cnt;
        rst   = 1'b1;
        a_req = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(60);
        chk("abort_no_ack", 32'(a_ack_cnt - cnt0), 32'd0);
        chk("reinit_pulse", 32'(latch_pulses - p0), 32'd1);
        chk("reinit_ce", 32'(last_ce), 32'h3);
        acc_a(24'h0002F0, lat);
        chk("a2_latency", 32'(lat), 32'd52);
        chk("a2_data_lit", 32'(a_rdata), 32'h9A93);

        cnt0    = b_ack_cnt;
        b_we    = 1'b0;
        b_addr  = 24'h000010;
        b_req   = 1'b1;
        tick(3);
        b_req = 1'b0;
        tick(100);
        chk("drop_one_ack", 32'(b_ack_cnt - cnt0), 32'd1);
        chk("drop_data_lit", 32'(b_rdata), 32'hA5);

        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
